exc_ctrl: RTL and testbench

Trap/interrupt sequencer that drives the CPU side of the CP0 exception interface. It accepts decoded SYSCALL/BREAK/TEQ/ERET events from the datapath and an external interrupt line, and gates them with CP0 `status`. It issues single-cycle `exception`/`eret` strobes with a 5-bit `cause` to CP0, stalls fetch, and redirects the PC to CP0's `exc_addr`. It sits between the decoder/ALU and CP0 and owns all trap ordering.

---
 rtl/exc_pkg.sv | 45 ++++
 rtl/exc_intr_pend.sv | 52 +++++
 rtl/exc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_exc_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exc_pkg
// Brief   : Shared constants for the trap/interrupt sequencer: CP0 cause
//           codes, status bit positions, FSM state encoding and a small
//           cause-selection helper.
// Rev     : 1.0  initial release
// ============================================================================
package exc_pkg;

  // CP0 cause codes presented with the exception strobe
  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;
  localparam logic [4:0] CAUSE_INT     = 5'b00000;

  // Bit positions inside the CP0 status register
  localparam int ST_IE  = 0;   // global enable
  localparam int ST_SYS = 1;   // SYSCALL enable
  localparam int ST_BRK = 2;   // BREAK enable
  localparam int ST_TEQ = 3;   // TEQ enable
  localparam int ST_INT = 4;   // external interrupt enable

  // Sequencer states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    EXC_IDLE  = 2'd0,
    EXC_ISSUE = 2'd1,
    EXC_REDIR = 2'd2,
    EXC_HOLD  = 2'd3
  } exc_state_e;

  // Cause code for a synchronous instruction trap. The decoder guarantees
  // at most one class bit is high, so TEQ is whatever is left over.
  function automatic logic [4:0] trap_cause(input logic is_sys, input logic is_brk);
    if (is_sys) begin
      return CAUSE_SYSCALL;
    end else if (is_brk) begin
      return CAUSE_BREAK;
    end else begin
      return CAUSE_TEQ;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_intr_pend.sv
`default_nettype none
// ============================================================================
// Module  : exc_intr_pend
// Brief   : External interrupt front end: 2-flop synchronizer, rising-edge
//           detector and a pending latch that is cleared when the sequencer
//           takes the interrupt. A new request needs intr to go low and then
//           high again. Only instantiated when EXC_CTRL_INTR_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module exc_intr_pend
  import exc_pkg::*;
(
  input  logic clk,
  input  logic rst,      // synchronous, active low
  input  logic i_intr,   // asynchronous level
  input  logic i_clr,    // sequencer accepted the pending interrupt
  output logic o_pend
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pend;
  logic w_rise;

  // A rise seen on the synchronized level; r_prev holds the previous level
  assign w_rise = r_sync2 & ~r_prev;

  // Synchronize, remember last level, and hold the request until taken.
  // A fresh edge arriving on the same edge as the clear wins, so it is not lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_sync1 <= i_intr;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_rise) begin
        r_pend <= 1'b1;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : exc_ctrl
// Brief   : Trap/interrupt sequencer on the CPU side of the CP0 exception
//           interface. Accepts SYSCALL/BREAK/TEQ/ERET from decode and an
//           external interrupt, gates them with CP0 status, issues a single
//           cycle exception/eret strobe with cause, stalls fetch and then
//           redirects the PC to CP0's exc_addr.
//           Build option: define EXC_CTRL_INTR_EN to compile in the
//           interrupt synchronizer, pending latch and INT path. Without it
//           intr is ignored and no INT exception is ever raised.
// Rev     : 1.0  initial release
// ============================================================================
module exc_ctrl #(
  parameter int HOLDOFF = 1     // interrupt blackout after ERET, 0..7 cycles
) (
  input  logic        clk,
  input  logic        rst,           // synchronous, active low
  input  logic        inst_valid,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_teq,
  input  logic        is_eret,
  input  logic        teq_eq,
  input  logic        intr,
  input  logic [31:0] status,
  input  logic [31:0] exc_addr,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        busy
);

  import exc_pkg::*;

  localparam logic [1:0] S_IDLE  = 2'(EXC_IDLE);
  localparam logic [1:0] S_ISSUE = 2'(EXC_ISSUE);
  localparam logic [1:0] S_REDIR = 2'(EXC_REDIR);
  localparam logic [1:0] S_HOLD  = 2'(EXC_HOLD);

  localparam logic [2:0] c_holdoff = 3'(HOLDOFF);

  logic [1:0] r_state;
  logic [4:0] r_cause;
  logic       r_is_eret;
  logic [2:0] r_cnt;

  logic w_idle;
  logic w_trap;
  logic w_eret_req;
  logic w_int_req;
  logic w_take_sync;
  logic w_take_int;
  logic w_accept;
  logic w_unused_ok;

  // Upper status bits carry nothing this block cares about
  assign w_unused_ok = ^status[31:5];

  assign w_idle = (r_state == S_IDLE);

  // A trap only fires when both the global enable and its own enable are set;
  // anything masked simply retires as a NOP and never reaches the FSM.
  assign w_trap = inst_valid & status[ST_IE] &
                  ((is_syscall & status[ST_SYS]) |
                   (is_break   & status[ST_BRK]) |
                   (is_teq & teq_eq & status[ST_TEQ]));

  // ERET is not maskable
  assign w_eret_req = inst_valid & is_eret;

`ifdef EXC_CTRL_INTR_EN
  logic w_pend;

  exc_intr_pend u_intr_pend (
    .clk    (clk),
    .rst    (rst),
    .i_intr (intr),
    .i_clr  (w_take_int),
    .o_pend (w_pend)
  );

  assign w_int_req = w_pend & status[ST_IE] & status[ST_INT];
`else
  logic w_unused_intr;

  assign w_unused_intr = intr;
  assign w_int_req     = 1'b0;
`endif

  // Instruction events outrank the interrupt; a losing interrupt stays
  // pending in the latch. Nothing is accepted while reset is asserted so
  // stall stays low during reset.
  assign w_take_sync = rst & w_idle & (w_trap | w_eret_req);
  assign w_take_int  = rst & w_idle & ~(w_trap | w_eret_req) & w_int_req;
  assign w_accept    = w_take_sync | w_take_int;

  // Sequencer: IDLE -> ISSUE -> REDIR -> (HOLD after ERET) -> IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cause   <= 5'd0;
      r_is_eret <= 1'b0;
      r_cnt     <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_ISSUE;
            r_is_eret <= w_take_sync & ~w_trap & w_eret_req;
            r_cause   <= w_take_int ? CAUSE_INT : trap_cause(is_syscall, is_break);
          end
        end
        S_ISSUE: begin
          r_state <= S_REDIR;
        end
        S_REDIR: begin
          if (r_is_eret && (c_holdoff != 3'd0)) begin
            r_state <= S_HOLD;
            r_cnt   <= c_holdoff;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          // One HOLD cycle per count; the counter lands on 0 as we leave
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: strobes in ISSUE, redirect in REDIR, stall from accept through ISSUE
  always_comb begin
    exception     = 1'b0;
    eret          = 1'b0;
    cause         = 5'd0;
    pc_redirect   = 1'b0;
    redirect_addr = 32'd0;
    stall         = w_accept;
    busy          = ~w_idle;
    case (r_state)
      S_ISSUE: begin
        stall = 1'b1;
        if (r_is_eret) begin
          eret = 1'b1;
        end else begin
          exception = 1'b1;
          cause     = r_cause;
        end
      end
      S_REDIR: begin
        // CP0 has already updated exc_addr by this cycle, so pass it straight through
        pc_redirect   = 1'b1;
        redirect_addr = exc_addr;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_exc_ctrl
// Brief   : Self-checking bench for exc_ctrl. Directed scenarios followed by
//           random stimulus, all compared against a timeline model: each
//           accepted event opens a window of known length and the outputs
//           are read off the position inside that window.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_exc_ctrl;

  localparam int HOLDOFF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid = 1'b0;
  logic        is_syscall = 1'b0;
  logic        is_break = 1'b0;
  logic        is_teq = 1'b0;
  logic        is_eret = 1'b0;
  logic        teq_eq = 1'b0;
  logic        intr = 1'b0;
  logic [31:0] status = 32'd0;
  logic [31:0] exc_addr = 32'd0;
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] redirect_addr;
  logic        busy;

  always #5 clk = ~clk;

  exc_ctrl #(.HOLDOFF(HOLDOFF)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_valid    (inst_valid),
    .is_syscall    (is_syscall),
    .is_break      (is_break),
    .is_teq        (is_teq),
    .is_eret       (is_eret),
    .teq_eq        (teq_eq),
    .intr          (intr),
    .status        (status),
    .exc_addr      (exc_addr),
    .exception     (exception),
    .eret          (eret),
    .cause         (cause),
    .stall         (stall),
    .pc_redirect   (pc_redirect),
    .redirect_addr (redirect_addr),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // Model: m_pos is the position inside an event window (1 = strobe cycle,
  // 2 = redirect cycle, 3.. = post-ERET blackout), -1 when idle.
  int         m_pos = -1;
  bit         m_is_eret = 0;
  logic [4:0] m_cause = 5'd0;
  bit         m_pend = 0;
  bit [3:0]   m_hist = 4'd0;   // intr as seen at the last four edges, newest in bit 0

  // Instruction classes for the stimulus helper
  localparam int K_NONE = 0, K_SYS = 1, K_BRK = 2, K_TEQ = 3, K_ERET = 4;

  // Drive one cycle of inputs, compare every output, then advance the model
  task automatic cyc(input logic r, input logic v, input int kind, input logic eq,
                     input logic irq, input logic [31:0] st, input logic [31:0] addr);
    bit idle, trap, er, irq_ok, acc_sync, acc_int, strobe;
    int win;
    @(negedge clk);
    rst        = r;
    inst_valid = v;
    is_syscall = (kind == K_SYS);
    is_break   = (kind == K_BRK);
    is_teq     = (kind == K_TEQ);
    is_eret    = (kind == K_ERET);
    teq_eq     = eq;
    intr       = irq;
    status     = st;
    exc_addr   = addr;
    #1;
    idle   = (m_pos < 0);
    trap   = v && st[0] && ((kind == K_SYS && st[1]) || (kind == K_BRK && st[2]) ||
                            (kind == K_TEQ && eq && st[3]));
    er     = v && (kind == K_ERET);
    irq_ok = 0;
`ifdef EXC_CTRL_INTR_EN
    irq_ok = m_pend && st[0] && st[4];
`endif
    acc_sync = idle && r && (trap || er);
    acc_int  = idle && r && !(trap || er) && irq_ok;
    strobe   = (m_pos == 1);
    check("stall",         stall,         (strobe || acc_sync || acc_int));
    check("exception",     exception,     (strobe && !m_is_eret));
    check("eret",          eret,          (strobe && m_is_eret));
    check("cause",         cause,         (strobe && !m_is_eret) ? m_cause : 5'd0);
    check("pc_redirect",   pc_redirect,   (m_pos == 2));
    check("redirect_addr", redirect_addr, (m_pos == 2) ? addr : 32'd0);
    check("busy",          busy,          (m_pos >= 1));
    @(posedge clk);
    if (!r) begin
      m_pos  = -1;
      m_pend = 0;
      m_hist = 4'd0;
    end else begin
      m_hist = {m_hist[2:0], irq};
      if (m_hist[2] && !m_hist[3]) m_pend = 1;
      else if (acc_int) m_pend = 0;
      if (m_pos >= 1) begin
        win   = 2 + (m_is_eret ? HOLDOFF : 0);
        m_pos = (m_pos + 1 > win) ? -1 : m_pos + 1;
      end else if (acc_sync || acc_int) begin
        m_pos     = 1;
        m_is_eret = acc_sync && !trap;
        m_cause   = acc_int ? 5'b00000 :
                    (kind == K_SYS) ? 5'b01000 :
                    (kind == K_BRK) ? 5'b01001 : 5'b01101;
      end
    end
  endtask

  task automatic idle_cycles(input int n, input logic irq, input logic [31:0] st);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, K_NONE, 1'b0, irq, st, 32'h00400004);
  endtask

  initial begin
    int kind;
    logic irq, r, v, eq;
    logic [31:0] st;
    // Reset
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, K_SYS, 1'b0, 1'b0, 32'h3, 32'h0);
    // SYSCALL with status 0x3, handler 0x00400004
    idle_cycles(2, 1'b0, 32'h3);
    cyc(1'b1, 1'b1, K_SYS, 1'b0, 1'b0, 32'h3, 32'h00400004);
    idle_cycles(4, 1'b0, 32'h3);
    // Masked or non-taken traps
    cyc(1'b1, 1'b1, K_TEQ, 1'b0, 1'b0, 32'hF, 32'h0);
    cyc(1'b1, 1'b1, K_BRK, 1'b0, 1'b0, 32'h1, 32'h0);
    cyc(1'b1, 1'b1, K_TEQ, 1'b1, 1'b0, 32'h9, 32'h00000180);
    idle_cycles(4, 1'b0, 32'h9);
    // ERET with intr held high and interrupts enabled
    idle_cycles(6, 1'b1, 32'h11);
    cyc(1'b1, 1'b1, K_ERET, 1'b0, 1'b1, 32'h11, 32'h00001000);
    idle_cycles(10, 1'b1, 32'h11);
    // intr rise with BREAK in the same cycle
    idle_cycles(3, 1'b0, 32'h15);
    cyc(1'b1, 1'b0, K_NONE, 1'b0, 1'b1, 32'h15, 32'h0);
    cyc(1'b1, 1'b0, K_NONE, 1'b0, 1'b1, 32'h15, 32'h0);
    cyc(1'b1, 1'b1, K_BRK, 1'b0, 1'b1, 32'h15, 32'h00000200);
    idle_cycles(8, 1'b1, 32'h15);
    // Reset during ISSUE
    idle_cycles(2, 1'b0, 32'h3);
    cyc(1'b1, 1'b1, K_SYS, 1'b0, 1'b0, 32'h3, 32'h00000300);
    cyc(1'b0, 1'b0, K_NONE, 1'b0, 1'b0, 32'h3, 32'h00000300);
    idle_cycles(4, 1'b0, 32'h3);
    // intr toggling with everything enabled
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, K_NONE, 1'b0, ((i / 5) % 2 == 1), 32'h1F, 32'h0);
    // Random traffic
    irq = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r    = ($urandom_range(0, 99) >= 2);
      v    = ($urandom_range(0, 99) < 80);
      kind = $urandom_range(0, 4);
      eq   = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) irq = ~irq;
      st   = $urandom;
      if ($urandom_range(0, 3) != 0) st[0] = 1'b1;
      cyc(r, v, kind, eq, irq, st, $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
